// File: rtl/core_id_ex.sv
// ============================================================================
// Module  : core_id_ex
// Purpose : ID->EX one-entry pipeline buffer with operand select, MEM/WB
//           forwarding and load-use stall, feeding core_alu.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_id_ex #(
  parameter int XLEN   = 32,
  parameter int FUNC_W = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_in,
  input  logic              id_valid_in,
  output logic              id_ready_out,
  input  logic [XLEN-1:0]   id_pc_in,
  input  logic [REG_AW-1:0] id_rs1_addr_in,
  input  logic [REG_AW-1:0] id_rs2_addr_in,
  input  logic [XLEN-1:0]   id_rs1_data_in,
  input  logic [XLEN-1:0]   id_rs2_data_in,
  input  logic [XLEN-1:0]   id_imm_in,
  input  logic [1:0]        id_op1_sel_in,
  input  logic              id_op2_sel_in,
  input  logic [FUNC_W-1:0] id_func_in,
  input  logic [REG_AW-1:0] id_rd_addr_in,
  input  logic              id_rd_we_in,
  input  logic              mem_rd_we_in,
  input  logic [REG_AW-1:0] mem_rd_addr_in,
  input  logic [XLEN-1:0]   mem_rd_data_in,
  input  logic              mem_data_ok_in,
  input  logic              wb_rd_we_in,
  input  logic [REG_AW-1:0] wb_rd_addr_in,
  input  logic [XLEN-1:0]   wb_rd_data_in,
  output logic              ex_valid_out,
  input  logic              ex_ready_in,
  output logic              alu_en_out,
  output logic [XLEN-1:0]   alu_op1_out,
  output logic [XLEN-1:0]   alu_op2_out,
  output logic [FUNC_W-1:0] alu_func_out,
  output logic [XLEN-1:0]   ex_rs2_out,
  output logic [XLEN-1:0]   ex_pc_out,
  output logic [REG_AW-1:0] ex_rd_addr_out,
  output logic              ex_rd_we_out
);

  localparam logic [REG_AW-1:0] c_X0 = '0;

  logic              r_full;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [1:0]        r_op1_sel;
  logic              r_op2_sel;
  logic [FUNC_W-1:0] r_func;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_rd_we;

  logic              w_mem_hit1, w_mem_hit2, w_wb_hit1, w_wb_hit2;
  logic              w_hazard, w_accept, w_consume;
  logic              w_in_wb_hit1, w_in_wb_hit2;
  logic [XLEN-1:0]   w_rs1_fwd, w_rs2_fwd;

  assign w_mem_hit1 = mem_rd_we_in && (r_rs1_addr != c_X0) && (mem_rd_addr_in == r_rs1_addr);
  assign w_mem_hit2 = mem_rd_we_in && (r_rs2_addr != c_X0) && (mem_rd_addr_in == r_rs2_addr);
  assign w_wb_hit1  = wb_rd_we_in  && (r_rs1_addr != c_X0) && (wb_rd_addr_in  == r_rs1_addr);
  assign w_wb_hit2  = wb_rd_we_in  && (r_rs2_addr != c_X0) && (wb_rd_addr_in  == r_rs2_addr);

  // MEM is younger than WB, so it wins when both target the same register
  assign w_rs1_fwd = w_mem_hit1 ? mem_rd_data_in : (w_wb_hit1 ? wb_rd_data_in : r_rs1_data);
  assign w_rs2_fwd = w_mem_hit2 ? mem_rd_data_in : (w_wb_hit2 ? wb_rd_data_in : r_rs2_data);

  // rs2 always counts as used because stores need it as write data
  assign w_hazard = !mem_data_ok_in &&
                    ((w_mem_hit1 && (r_op1_sel == 2'b00)) || w_mem_hit2);

  assign ex_valid_out = r_full && !w_hazard && !flush_in;
  assign alu_en_out   = ex_valid_out;
  assign id_ready_out = !flush_in && (!r_full || (ex_valid_out && ex_ready_in));
  assign w_accept     = id_valid_in && id_ready_out;
  assign w_consume    = ex_valid_out && ex_ready_in;

  assign w_in_wb_hit1 = wb_rd_we_in && (id_rs1_addr_in != c_X0) && (wb_rd_addr_in == id_rs1_addr_in);
  assign w_in_wb_hit2 = wb_rd_we_in && (id_rs2_addr_in != c_X0) && (wb_rd_addr_in == id_rs2_addr_in);

  always_comb begin
    alu_op1_out = '0;
    case (r_op1_sel)
      2'b00:   alu_op1_out = w_rs1_fwd;
      2'b01:   alu_op1_out = r_pc;
      default: alu_op1_out = '0;
    endcase
  end

  assign alu_op2_out    = r_op2_sel ? r_imm : w_rs2_fwd;
  assign alu_func_out   = r_func;
  assign ex_rs2_out     = w_rs2_fwd;
  assign ex_pc_out      = r_pc;
  assign ex_rd_addr_out = r_rd_addr;
  assign ex_rd_we_out   = r_rd_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= 1'b0;
      r_pc       <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_op1_sel  <= '0;
      r_op2_sel  <= 1'b0;
      r_func     <= '0;
      r_rd_addr  <= '0;
      r_rd_we    <= 1'b0;
    end else if (w_accept) begin
      r_full     <= 1'b1;
      r_pc       <= id_pc_in;
      r_rs1_addr <= id_rs1_addr_in;
      r_rs2_addr <= id_rs2_addr_in;
      r_rs1_data <= w_in_wb_hit1 ? wb_rd_data_in : id_rs1_data_in;
      r_rs2_data <= w_in_wb_hit2 ? wb_rd_data_in : id_rs2_data_in;
      r_imm      <= id_imm_in;
      r_op1_sel  <= id_op1_sel_in;
      r_op2_sel  <= id_op2_sel_in;
      r_func     <= id_func_in;
      r_rd_addr  <= id_rd_addr_in;
      r_rd_we    <= id_rd_we_in;
    end else begin
      if (flush_in || w_consume)
        r_full <= 1'b0;
      // Held entries absorb WB writes so the value survives after WB moves on
      if (r_full && w_wb_hit1)
        r_rs1_data <= wb_rd_data_in;
      if (r_full && w_wb_hit2)
        r_rs2_data <= wb_rd_data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_id_ex.sv
// Testbench for core_id_ex: vector table for single-entry operand/forwarding
// cases plus directed multi-cycle sequences (stall, hold, flush, reset).
`default_nettype none

module tb_core_id_ex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_in;
  logic        id_valid_in;
  logic        id_ready_out;
  logic [31:0] id_pc_in;
  logic [4:0]  id_rs1_addr_in, id_rs2_addr_in;
  logic [31:0] id_rs1_data_in, id_rs2_data_in, id_imm_in;
  logic [1:0]  id_op1_sel_in;
  logic        id_op2_sel_in;
  logic [3:0]  id_func_in;
  logic [4:0]  id_rd_addr_in;
  logic        id_rd_we_in;
  logic        mem_rd_we_in;
  logic [4:0]  mem_rd_addr_in;
  logic [31:0] mem_rd_data_in;
  logic        mem_data_ok_in;
  logic        wb_rd_we_in;
  logic [4:0]  wb_rd_addr_in;
  logic [31:0] wb_rd_data_in;
  logic        ex_valid_out;
  logic        ex_ready_in;
  logic        alu_en_out;
  logic [31:0] alu_op1_out, alu_op2_out, ex_rs2_out, ex_pc_out;
  logic [3:0]  alu_func_out;
  logic [4:0]  ex_rd_addr_out;
  logic        ex_rd_we_out;

  int checks = 0;
  int errors = 0;

  core_id_ex #(.XLEN(32), .FUNC_W(4), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
    .id_valid_in(id_valid_in), .id_ready_out(id_ready_out),
    .id_pc_in(id_pc_in), .id_rs1_addr_in(id_rs1_addr_in), .id_rs2_addr_in(id_rs2_addr_in),
    .id_rs1_data_in(id_rs1_data_in), .id_rs2_data_in(id_rs2_data_in), .id_imm_in(id_imm_in),
    .id_op1_sel_in(id_op1_sel_in), .id_op2_sel_in(id_op2_sel_in), .id_func_in(id_func_in),
    .id_rd_addr_in(id_rd_addr_in), .id_rd_we_in(id_rd_we_in),
    .mem_rd_we_in(mem_rd_we_in), .mem_rd_addr_in(mem_rd_addr_in), .mem_rd_data_in(mem_rd_data_in),
    .mem_data_ok_in(mem_data_ok_in),
    .wb_rd_we_in(wb_rd_we_in), .wb_rd_addr_in(wb_rd_addr_in), .wb_rd_data_in(wb_rd_data_in),
    .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in), .alu_en_out(alu_en_out),
    .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out), .alu_func_out(alu_func_out),
    .ex_rs2_out(ex_rs2_out), .ex_pc_out(ex_pc_out), .ex_rd_addr_out(ex_rd_addr_out),
    .ex_rd_we_out(ex_rd_we_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op1s;
    logic        op2s;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        mwe;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        mok;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] e1, e2, ers2;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [1:0] op1s, input logic op2s,
                          input logic [4:0] rs1a, input logic [31:0] rs1d,
                          input logic [4:0] rs2a, input logic [31:0] rs2d,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [3:0] func, input logic [4:0] rd);
    id_op1_sel_in = op1s;  id_op2_sel_in = op2s;
    id_rs1_addr_in = rs1a; id_rs1_data_in = rs1d;
    id_rs2_addr_in = rs2a; id_rs2_data_in = rs2d;
    id_imm_in = imm; id_pc_in = pc; id_func_in = func;
    id_rd_addr_in = rd; id_rd_we_in = 1'b1;
  endtask

  task automatic idle_fwd();
    mem_rd_we_in = 1'b0; mem_rd_addr_in = '0; mem_rd_data_in = '0; mem_data_ok_in = 1'b1;
    wb_rd_we_in = 1'b0;  wb_rd_addr_in = '0;  wb_rd_data_in = '0;
  endtask

  initial begin
    //        op1s  op2s rs1a rs2a  rs1d      rs2d      imm           pc          fn    rd     mwe  ma    md         mok  wwe  wa     wd         ev   e1            e2            ers2
    v[0] = '{2'b00, 1'b1, 5'd0, 5'd0, 32'h0,   32'h0,   32'h5,        32'h100,  4'd0, 5'd1,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 32'h0,       32'h5,        32'h0};
    v[1] = '{2'b00, 1'b0, 5'd3, 5'd4, 32'h7,   32'h100, 32'h0,        32'h104,  4'd1, 5'd2,  1'b1, 5'd3, 32'h9,    1'b1, 1'b1, 5'd3,  32'h4,    1'b1, 32'h9,       32'h100,      32'h100};
    v[2] = '{2'b00, 1'b0, 5'd0, 5'd0, 32'h0,   32'h0,   32'h0,        32'h108,  4'd2, 5'd3,  1'b1, 5'd0, 32'h9,    1'b0, 1'b1, 5'd0,  32'h4,    1'b1, 32'h0,       32'h0,        32'h0};
    v[3] = '{2'b01, 1'b0, 5'd1, 5'd7, 32'h11,  32'h3,   32'h0,        32'h1000, 4'd3, 5'd4,  1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd7,  32'h55,   1'b1, 32'h1000,    32'h55,       32'h55};
    v[4] = '{2'b10, 1'b1, 5'd2, 5'd0, 32'h22,  32'h0,   32'hFFFFFFF0, 32'h10C,  4'd4, 5'd5,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 32'h0,       32'hFFFFFFF0, 32'h0};
    v[5] = '{2'b11, 1'b1, 5'd8, 5'd0, 32'h33,  32'h0,   32'h8,        32'h110,  4'd5, 5'd6,  1'b1, 5'd8, 32'h99,   1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 32'h0,       32'h8,        32'h0};
    v[6] = '{2'b00, 1'b1, 5'd8, 5'd0, 32'h33,  32'h0,   32'h8,        32'h114,  4'd6, 5'd7,  1'b1, 5'd8, 32'h99,   1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 32'h99,      32'h8,        32'h0};
    v[7] = '{2'b00, 1'b0, 5'd9, 5'd10,32'h44,  32'h5,   32'h0,        32'h118,  4'd15,5'd31, 1'b1, 5'd10,32'hAA,   1'b1, 1'b1, 5'd10, 32'hBB,   1'b1, 32'h44,      32'hAA,       32'hAA};
    v[8] = '{2'b00, 1'b1, 5'd11,5'd0, 32'h1,   32'h0,   32'h0,        32'h11C,  4'd7, 5'd8,  1'b0, 5'd11,32'hDEAD, 1'b0, 1'b1, 5'd11, 32'h66,   1'b1, 32'h66,      32'h0,        32'h0};

    rst_n = 1'b0; flush_in = 1'b0; id_valid_in = 1'b0; ex_ready_in = 1'b1;
    drive_id(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0);
    idle_fwd();
    #2;
    chk("reset ex_valid", {31'b0, ex_valid_out}, 32'h0);
    chk("reset alu_en", {31'b0, alu_en_out}, 32'h0);
    chk("reset id_ready", {31'b0, id_ready_out}, 32'h1);
    chk("reset op1", alu_op1_out, 32'h0);
    chk("reset pc", ex_pc_out, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      idle_fwd();
      drive_id(v[i].op1s, v[i].op2s, v[i].rs1a, v[i].rs1d, v[i].rs2a, v[i].rs2d,
               v[i].imm, v[i].pc, v[i].func, v[i].rd);
      id_valid_in = 1'b1;
      #1;
      chk($sformatf("v%0d pre-accept valid", i), {31'b0, ex_valid_out}, 32'h0);
      chk($sformatf("v%0d id_ready", i), {31'b0, id_ready_out}, 32'h1);
      tick();
      id_valid_in = 1'b0;
      mem_rd_we_in = v[i].mwe; mem_rd_addr_in = v[i].ma; mem_rd_data_in = v[i].md;
      mem_data_ok_in = v[i].mok;
      wb_rd_we_in = v[i].wwe; wb_rd_addr_in = v[i].wa; wb_rd_data_in = v[i].wd;
      #1;
      chk($sformatf("v%0d ex_valid", i), {31'b0, ex_valid_out}, {31'b0, v[i].ev});
      chk($sformatf("v%0d alu_en", i), {31'b0, alu_en_out}, {31'b0, v[i].ev});
      chk($sformatf("v%0d op1", i), alu_op1_out, v[i].e1);
      chk($sformatf("v%0d op2", i), alu_op2_out, v[i].e2);
      chk($sformatf("v%0d rs2", i), ex_rs2_out, v[i].ers2);
      chk($sformatf("v%0d func", i), {28'b0, alu_func_out}, {28'b0, v[i].func});
      chk($sformatf("v%0d pc", i), ex_pc_out, v[i].pc);
      chk($sformatf("v%0d rd", i), {27'b0, ex_rd_addr_out}, {27'b0, v[i].rd});
      idle_fwd();
      tick();
    end

    // Load-use stall on rs2 until MEM data arrives
    drive_id(2'b10, 1'b0, 5'd0, 32'h0, 5'd5, 32'h1, 32'h0, 32'h200, 4'd0, 5'd9);
    id_valid_in = 1'b1;
    tick();
    id_valid_in = 1'b0;
    mem_rd_we_in = 1'b1; mem_rd_addr_in = 5'd5; mem_rd_data_in = 32'h0; mem_data_ok_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("loaduse stall%0d valid", c), {31'b0, ex_valid_out}, 32'h0);
      chk($sformatf("loaduse stall%0d alu_en", c), {31'b0, alu_en_out}, 32'h0);
      tick();
    end
    mem_data_ok_in = 1'b1; mem_rd_data_in = 32'h2A;
    #1;
    chk("loaduse release valid", {31'b0, ex_valid_out}, 32'h1);
    chk("loaduse op2", alu_op2_out, 32'h2A);
    chk("loaduse rs2", ex_rs2_out, 32'h2A);
    idle_fwd();
    tick();

    // Downstream backpressure with WB refresh of the held rs1
    drive_id(2'b00, 1'b1, 5'd6, 32'h3, 5'd0, 32'h0, 32'h0, 32'h300, 4'd0, 5'd10);
    id_valid_in = 1'b1;
    tick();
    ex_ready_in = 1'b0;
    drive_id(2'b01, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h4, 32'h400, 4'd1, 5'd11);
    wb_rd_we_in = 1'b1; wb_rd_addr_in = 5'd6; wb_rd_data_in = 32'h11;
    #1;
    chk("hold id_ready c0", {31'b0, id_ready_out}, 32'h0);
    chk("hold op1 c0", alu_op1_out, 32'h11);
    tick();
    idle_fwd();
    for (int c = 1; c < 4; c++) begin
      #1;
      chk($sformatf("hold id_ready c%0d", c), {31'b0, id_ready_out}, 32'h0);
      chk($sformatf("hold op1 c%0d", c), alu_op1_out, 32'h11);
      chk($sformatf("hold pc c%0d", c), ex_pc_out, 32'h300);
      tick();
    end
    ex_ready_in = 1'b1;
    #1;
    chk("hold release id_ready", {31'b0, id_ready_out}, 32'h1);
    tick();
    chk("replace pc", ex_pc_out, 32'h400);
    chk("replace valid", {31'b0, ex_valid_out}, 32'h1);
    chk("replace op1", alu_op1_out, 32'h400);
    id_valid_in = 1'b0;
    tick();
    chk("drained valid", {31'b0, ex_valid_out}, 32'h0);

    // Flush with entry full and a new instruction offered
    drive_id(2'b01, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h500, 4'd2, 5'd12);
    id_valid_in = 1'b1;
    tick();
    drive_id(2'b01, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h600, 4'd3, 5'd13);
    flush_in = 1'b1; ex_ready_in = 1'b0;
    #1;
    chk("flush same valid", {31'b0, ex_valid_out}, 32'h0);
    chk("flush same id_ready", {31'b0, id_ready_out}, 32'h0);
    tick();
    flush_in = 1'b0; id_valid_in = 1'b0;
    #1;
    chk("flush next valid", {31'b0, ex_valid_out}, 32'h0);
    chk("flush no accept pc", ex_pc_out, 32'h500);
    chk("flush next id_ready", {31'b0, id_ready_out}, 32'h1);

    // WB write captured at accept time, then async reset while holding
    drive_id(2'b00, 1'b1, 5'd12, 32'h1, 5'd0, 32'h0, 32'h0, 32'h700, 4'd4, 5'd14);
    wb_rd_we_in = 1'b1; wb_rd_addr_in = 5'd12; wb_rd_data_in = 32'h77;
    id_valid_in = 1'b1;
    tick();
    idle_fwd();
    id_valid_in = 1'b0;
    #1;
    chk("accept wb capture op1", alu_op1_out, 32'h77);
    chk("accept wb capture valid", {31'b0, ex_valid_out}, 32'h1);
    tick();
    chk("hold before reset valid", {31'b0, ex_valid_out}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset valid", {31'b0, ex_valid_out}, 32'h0);
    chk("midreset op1", alu_op1_out, 32'h0);
    chk("midreset pc", ex_pc_out, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post reset id_ready", {31'b0, id_ready_out}, 32'h1);
    chk("post reset valid", {31'b0, ex_valid_out}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
